// File: rtl/mips_mmio_port_if.sv
// Data-memory bus bundle between the MIPS core and the MMIO port.
// The core drives address/strobes; the port returns load data and Hit.
interface mips_mmio_port_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData,
        input  Hit
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData,
        output Hit
    );
endinterface

// File: rtl/mips_mmio_port.sv
// Memory-mapped I/O port: output register, synchronized input with
// change flag, and a down-counting timer with expiry flag and IRQ.
module mips_mmio_port #(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
    parameter int          SYNC_STAGES = 2,
    parameter int          TIMER_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    mips_mmio_port_if.slave   bus,
    input  logic [7:0]        PortIn,
    output logic [31:0]       PortOut,
    output logic              IRQ
);

    localparam int TW = TIMER_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } tmr_state_e;

    logic              hit;
    logic [2:0]        sel;
    logic              wr;
    logic              out_wr;
    logic              st_wr;
    logic              ld_wr;
    logic              ctl_wr;
    logic [TW-1:0]     wdata_t;
    logic              expire;
    logic [31:0]       rdata;

    logic [31:0]       out_q, out_d;
    logic [TW-1:0]     load_q, load_d;
    logic [TW-1:0]     count_q, count_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              in_chg_q, in_chg_d;
    logic              tmr_exp_q, tmr_exp_d;
    tmr_state_e        state_q, state_d;
    logic [7:0]        sync_q [SYNC_STAGES];
    logic [7:0]        sync_d [SYNC_STAGES];
    logic [7:0]        hist_q, hist_d;
    logic [7:0]        in_val;

    assign hit = (bus.Address >= BASE_ADDR)
              && (bus.Address <= BASE_ADDR + 32'h17);
    assign sel     = bus.Address[4:2];
    assign wr      = hit && bus.MemWrite;
    assign out_wr  = wr && (sel == 3'd0);
    assign st_wr   = wr && (sel == 3'd2);
    assign ld_wr   = wr && (sel == 3'd3);
    assign ctl_wr  = wr && (sel == 3'd5);
    assign wdata_t = bus.WriteData[TW-1:0];
    assign in_val  = sync_q[SYNC_STAGES-1];

    // Load data mux; zero outside the window or without MemRead.
    always_comb begin
        rdata = 32'h0;
        if (hit && bus.MemRead) begin
            case (sel)
                3'd0:    rdata = out_q;
                3'd1:    rdata = {24'h0, in_val};
                3'd2:    rdata = {30'h0, tmr_exp_q, in_chg_q};
                3'd3:    rdata = 32'(load_q);
                3'd4:    rdata = 32'(count_q);
                3'd5:    rdata = {29'h0, ctrl_q};
                default: rdata = 32'h0;
            endcase
        end
    end

    assign bus.ReadData = rdata;
    assign bus.Hit      = hit;

    // Software-visible registers and input synchronizer next state.
    always_comb begin
        out_d  = out_wr ? bus.WriteData : out_q;
        load_d = ld_wr ? wdata_t : load_q;
        ctrl_d = ctl_wr ? bus.WriteData[2:0] : ctrl_q;
        sync_d[0] = PortIn;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d = in_val;
        in_chg_d = (in_chg_q & ~(st_wr & bus.WriteData[0]))
                 | (in_val != hist_q);
        tmr_exp_d = (tmr_exp_q & ~(st_wr & bus.WriteData[1]))
                  | expire;
    end

    // Timer next state; a LOAD write overrides the countdown result.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expire  = (state_q == S_RUN) && (count_q == TW'(1));
        case (state_q)
            S_IDLE: begin
                count_d = count_q;
            end
            S_RUN: begin
                if (expire) begin
                    if (ctrl_q[0]) begin
                        count_d = load_q;
                    end else begin
                        count_d = '0;
                        state_d = S_DONE;
                    end
                end else begin
                    count_d = count_q - TW'(1);
                end
            end
            S_DONE: begin
                count_d = '0;
                if (st_wr && bus.WriteData[1]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        if (ld_wr) begin
            if (wdata_t != '0) begin
                count_d = wdata_t;
                state_d = S_RUN;
            end else begin
                count_d = '0;
                state_d = S_IDLE;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q     <= 32'h0;
            load_q    <= '0;
            count_q   <= '0;
            ctrl_q    <= 3'h0;
            in_chg_q  <= 1'b0;
            tmr_exp_q <= 1'b0;
            state_q   <= S_IDLE;
            hist_q    <= 8'h0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 8'h0;
            end
        end else begin
            out_q     <= out_d;
            load_q    <= load_d;
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
            in_chg_q  <= in_chg_d;
            tmr_exp_q <= tmr_exp_d;
            state_q   <= state_d;
            hist_q    <= hist_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign PortOut = out_q;
    assign IRQ = (in_chg_q & ctrl_q[1]) | (tmr_exp_q & ctrl_q[2]);

endmodule

// File: doc/mips_mmio_port.md
Name: mips_mmio_port

Overview:
- Memory-mapped I/O peripheral sitting downstream of the single-cycle MIPS core's data-memory bus, in parallel with DataMemory.
- Decodes the core's ALU-computed address and MemWrite/MemRead strobes.
- Drives the top-level PortOut and synchronizes the 8-bit PortIn.
- Provides a down-counting timer with sticky event flags and an interrupt line.

Parameters:
- BASE_ADDR, 32'hFFFF0000: byte address of register 0x00; must be 32-byte aligned.
- SYNC_STAGES, 2: flip-flop depth of the PortIn synchronizer; minimum 2.
- TIMER_WIDTH, 32: width of the timer load and count registers; maximum 32.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
- Address  in  32  byte address from ALU result.
- WriteData  in  32  store data (ReadData2 of register file).
- MemWrite  in  1  store strobe; write takes effect at next rising edge.
- MemRead  in  1  load strobe.
- PortIn  in  8  asynchronous external input.
- ReadData  out  32  load data, combinational.
- Hit  out  1  combinational; 1 when Address is inside the 0x00-0x17 window. Top level uses it to select ReadData over DataMemory and to gate DataMemory writes.
- PortOut  out  32  output register.
- IRQ  out  1  interrupt request, level.

Behaviour:
- Decode:
  - Hit = (Address >= BASE_ADDR) && (Address <= BASE_ADDR+0x17).
  - Register select = Address[4:2]; Address[1:0] ignored.
- Register map:
  - 0x00 OUT: RW.
  - 0x04 IN: RO; {24'b0, synchronized PortIn}.
  - 0x08 STATUS: RW1C. bit0 IN_CHG, bit1 TMR_EXP; other bits read 0.
  - 0x0C LOAD: RW; timer reload value.
  - 0x10 COUNT: RO.
  - 0x14 CTRL: RW bits[2:0]. bit0 AUTO_RELOAD, bit1 IE_CHG, bit2 IE_TMR; other bits read 0.
- Read/write rules:
  - ReadData = selected register when Hit & MemRead, else 0. Reads have no side effects.
  - Writes require Hit & MemWrite and occur at the clock edge.
  - Writes to RO registers and non-Hit addresses are ignored.
  - Register fields narrower than 32 bits read zero-extended; writes truncate.
  - MemRead & MemWrite together: the read returns the pre-write value.
- Reset (reset==0 at edge): OUT, LOAD, COUNT, CTRL, STATUS and all synchronizer flops = 0; timer state IDLE; PortOut=0, IRQ=0. Reset overrides any concurrent write; mid-countdown reset aborts to IDLE with COUNT=0.
- Input synchronizer:
  - SYNC_STAGES-deep chain plus one history flop.
  - IN reflects the last synchronizer stage: a PortIn change before edge k is readable after edge k+SYNC_STAGES-1.
  - IN_CHG is set at the following edge when the last stage differs from the history flop.
  - Set and W1C clear in the same cycle: set wins.
- Timer FSM (IDLE, RUN, DONE):
  - Write LOAD=N, N!=0, from any state: next edge COUNT=N, state RUN.
  - Write LOAD=0 from any state: COUNT=0, state IDLE, no flag.
  - RUN with no LOAD write: COUNT decrements by 1 per cycle.
  - RUN, edge where COUNT==1: TMR_EXP set. If AUTO_RELOAD: COUNT=LOAD, stay RUN (period = LOAD cycles). Else: COUNT=0, state DONE.
  - DONE: holds COUNT=0; goes to IDLE when TMR_EXP is cleared via W1C.
  - LOAD write on the same edge as expiry: the write wins (COUNT=new N, RUN), but TMR_EXP is still set.
  - Expiry coincident with a W1C of bit1: set wins.
- IRQ = (IN_CHG & IE_CHG) | (TMR_EXP & IE_TMR), from registered state only (no combinational path from bus inputs).

Test Plan:
- Reset, then assert reset=0 at one edge during RUN with COUNT=7 → all registers 0, state IDLE, PortOut=0, IRQ=0, Hit still decodes.
- Store 0xDEADBEEF to BASE+0x00 → PortOut=0xDEADBEEF after the edge. Load BASE+0x00 → ReadData=0xDEADBEEF. Store to BASE+0x04 → IN unchanged. Address 0xFFFF0018 → Hit=0, ReadData=0.
- PortIn 0x00→0xA5 just before edge 1 (SYNC_STAGES=2) → IN reads 0xA5 after edge 2; STATUS=0x1 after edge 3. With IE_CHG=1, IRQ rises with the flag; W1C 0x1 clears both.
- CTRL=0x4, LOAD=3 → COUNT 3,2,1 on successive cycles. On the next edge STATUS bit1=1, COUNT=0, state DONE, IRQ=1. W1C 0x2 → IDLE, IRQ=0.
- CTRL=0x1, LOAD=2 → TMR_EXP set every 2 cycles; COUNT pattern 2,1,2,1. W1C of bit1 on an expiry edge leaves the flag set.
- LOAD=5 written during RUN at COUNT=1 → COUNT=5 next cycle, TMR_EXP set once. LOAD=0 → IDLE, COUNT=0, no new flag.
